// File: rtl/core_pipe_exec_bru.sv
// Execute-stage branch resolution unit: resolves branches/jumps/system ops and requests a
// held fetch redirect on misprediction. Optional counters behind CORE_BRU_PERF_CNT_EN.
module core_pipe_exec_bru #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned IALIGN = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            new_instr,
  input  logic            valid,
  input  logic            cmp_eq,
  input  logic            cmp_lt,
  input  logic            cmp_ltu,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] npc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] offset,
  input  logic            op_beq,
  input  logic            op_bne,
  input  logic            op_blt,
  input  logic            op_bge,
  input  logic            op_bltu,
  input  logic            op_bgeu,
  input  logic            op_jal,
  input  logic            op_jalr,
  input  logic            op_ebrk,
  input  logic            op_ecall,
  input  logic            op_mret,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            cf_valid,
  input  logic            cf_ack,
  output logic [XLEN-1:0] cf_target,
  output logic [2:0]      new_op,
  output logic            rd_wen,
  output logic [XLEN-1:0] rd_wdata,
  output logic            trap_raise,
  output logic [6:0]      trap_cause,
  output logic            mispredict,
`ifdef CORE_BRU_PERF_CNT_EN
  output logic            finished,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`else
  output logic            finished
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            is_cond, is_jump, taken, misaligned, trap_int, redirect;
  logic [XLEN-1:0] raw_target, target, resolved_target;

  assign is_cond = op_beq | op_bne | op_blt | op_bge | op_bltu | op_bgeu;
  assign is_jump = op_jal | op_jalr;

  assign taken = is_jump
               | (op_beq  &  cmp_eq)  | (op_bne  & ~cmp_eq)
               | (op_blt  &  cmp_lt)  | (op_bge  & ~cmp_lt)
               | (op_bltu &  cmp_ltu) | (op_bgeu & ~cmp_ltu);

  assign raw_target      = (op_jalr ? rs1 : pc) + offset;
  assign target          = op_jalr ? {raw_target[XLEN-1:1], 1'b0} : raw_target;
  assign resolved_target = taken ? target : npc;

  if (IALIGN == 32) begin : g_align32
    assign misaligned = taken && (target[1:0] != 2'b00);
  end else begin : g_align16
    assign misaligned = taken && target[0];
  end

  assign trap_int = valid & (op_ebrk | op_ecall | misaligned);
  assign redirect = valid && !trap_int && !op_mret &&
                    ((taken != pred_taken) || (taken && (target != pred_target)));

  assign trap_raise = trap_int;
  assign mispredict = redirect;
  assign rd_wen     = valid & is_jump & ~trap_int;
  assign rd_wdata   = valid ? npc : '0;

  always_comb begin
    trap_cause = 7'd0;
    if (trap_int) begin
      if (op_ecall)     trap_cause = 7'd11;
      else if (op_ebrk) trap_cause = 7'd3;
      else              trap_cause = 7'd0;
    end
  end

  always_comb begin
    new_op = 3'd0;
    if (valid) begin
      if (trap_int)     new_op = 3'd3;
      else if (op_mret) new_op = 3'd4;
      else if (taken)   new_op = 3'd1;
      else if (is_cond) new_op = 3'd2;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cf_valid  = 1'b0;
    cf_target = '0;
    unique case (state_q)
      StIdle: begin
        cf_valid  = redirect;
        cf_target = valid ? resolved_target : '0;
        if (redirect) begin
          target_d = resolved_target;
          state_d  = cf_ack ? StDone : StReq;
        end
      end
      StReq: begin
        // Held from the captured copy so the request is stable while inputs move.
        cf_valid  = 1'b1;
        cf_target = target_q;
        if (cf_ack) state_d = StDone;
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
    if (new_instr) state_d = StIdle;
  end

  assign finished = valid && (trap_int || op_mret || !redirect ||
                              (cf_ack && (state_q != StDone)) || (state_q == StDone));

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q  <= StIdle;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

`ifdef CORE_BRU_PERF_CNT_EN
  logic        counted_q, counted_d, count_en, done_entry;
  logic [31:0] perf_branches_q, perf_mispredicts_q;

  // A new_instr cycle may itself carry the instruction, so it both clears and re-arms the guard.
  assign count_en   = valid && (is_cond || is_jump) && (new_instr || !counted_q);
  assign counted_d  = new_instr ? count_en : (counted_q | count_en);
  assign done_entry = (state_q != StDone) && (state_d == StDone);

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      counted_q          <= 1'b0;
      perf_branches_q    <= 32'd0;
      perf_mispredicts_q <= 32'd0;
    end else begin
      counted_q <= counted_d;
      if (count_en && (perf_branches_q != 32'hFFFF_FFFF)) begin
        perf_branches_q <= perf_branches_q + 32'd1;
      end
      if (done_entry && (perf_mispredicts_q != 32'hFFFF_FFFF)) begin
        perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
      end
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule
